// File: rtl/omsp_spm_violation_ctl_if.sv
// openMSP430 peripheral bus bundle for the SPM violation controller.
// The CPU side is the master; the peripheral answers on per_dout.
interface omsp_spm_violation_ctl_if;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;

  modport master (
    output per_en, per_we, per_addr, per_din,
    input  per_dout
  );

  modport slave (
    input  per_en, per_we, per_addr, per_din,
    output per_dout
  );
endinterface

// File: rtl/omsp_spm_violation_ctl.sv
// SPM violation recorder: edge-detects violations, latches the first
// offending context, raises an IRQ and escalates to a reset request.
module omsp_spm_violation_ctl #(
  parameter logic [13:0] BASE_ADDR  = 14'h0190,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        violation,
  input  logic        exec_violation,
  input  logic [15:0] spm_current_id,
  input  logic [15:0] spm_prev_id,
  input  logic [15:0] pc,
  input  logic        irq_acc,
  omsp_spm_violation_ctl_if.slave bus,
  output logic        viol_irq,
  output logic        viol_rst_req
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_ESCAL
  } state_t;

  localparam logic [7:0] TMR_INIT = 8'(RST_CYCLES - 1);

  state_t      r_state;
  logic        r_irq;
  logic        r_rst_req;
  logic [7:0]  r_timer;
  logic        r_v_d;
  logic        r_x_d;
  logic        r_en;
  logic        r_esc;
  logic        r_ovf;
  logic [15:0] r_vpc;
  logic [15:0] r_vid;
  logic [15:0] r_vprev;
  logic [1:0]  r_cause;
  logic [15:0] r_count;

  logic        w_ev_v;
  logic        w_ev_x;
  logic        w_event;
  logic [1:0]  w_cause;
  logic        w_cap;
  logic [13:0] w_off;
  logic        w_hit;
  logic        w_rd;
  logic        w_wr;
  logic        w_wr_ctl;
  logic        w_wr_cnt;
  logic [15:0] w_rdata;
  logic        w_pend;
  logic        w_unused;

  assign w_ev_v  = violation & ~r_v_d;
  assign w_ev_x  = exec_violation & ~r_x_d;
  assign w_event = w_ev_v | w_ev_x;
  assign w_cause = {w_ev_x, w_ev_v};
  assign w_pend  = (r_state == S_PEND);

  // A fresh record is taken from IDLE (when enabled) or when an ack
  // and a new event coincide in PEND; otherwise the first one sticks.
  assign w_cap = w_event &
                 (((r_state == S_IDLE) & r_en) |
                  (w_pend & irq_acc));

  assign w_off    = bus.per_addr - BASE_ADDR;
  assign w_hit    = bus.per_en &&
                    (bus.per_addr >= BASE_ADDR) &&
                    (w_off < 14'd6);
  assign w_rd     = w_hit && (bus.per_we == 2'b00);
  assign w_wr     = w_hit && (bus.per_we != 2'b00);
  assign w_wr_ctl = w_wr && (w_off == 14'd0);
  assign w_wr_cnt = w_wr && (w_off == 14'd5);

  assign w_unused = &{1'b0, bus.per_din[15:3]};

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_v_d <= 1'b0;
      r_x_d <= 1'b0;
    end else begin
      r_v_d <= violation;
      r_x_d <= exec_violation;
    end
  end

  // A clear coinciding with an event leaves that event counted.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_count <= 16'h0000;
    end else if (w_wr_cnt) begin
      r_count <= w_event ? 16'h0001 : 16'h0000;
    end else if (w_event && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'h0001;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_en  <= 1'b1;
      r_esc <= 1'b0;
    end else if (w_wr_ctl) begin
      r_en  <= bus.per_din[0];
      r_esc <= bus.per_din[1];
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_vpc   <= 16'h0000;
      r_vid   <= 16'h0000;
      r_vprev <= 16'h0000;
      r_cause <= 2'b00;
    end else if (w_cap) begin
      r_vpc   <= pc;
      r_vid   <= spm_current_id;
      r_vprev <= spm_prev_id;
      r_cause <= w_cause;
    end
  end

  // OVF software clear comes first so a same-cycle hardware set wins.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_rst_req <= 1'b0;
      r_timer   <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_ctl && bus.per_din[2]) begin
        r_ovf <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_event && r_en) begin
            r_state <= S_PEND;
            r_irq   <= 1'b1;
          end
        end
        S_PEND: begin
          if (irq_acc && w_event) begin
            r_irq <= 1'b1;
          end else if (irq_acc) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
          end else if (w_event && r_esc) begin
            r_state   <= S_ESCAL;
            r_irq     <= 1'b0;
            r_rst_req <= 1'b1;
            r_timer   <= TMR_INIT;
          end else if (w_event) begin
            r_ovf <= 1'b1;
          end
        end
        S_ESCAL: begin
          if (r_timer == 8'h00) begin
            r_state   <= S_IDLE;
            r_rst_req <= 1'b0;
          end else begin
            r_timer <= r_timer - 8'h01;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_irq     <= 1'b0;
          r_rst_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (w_off)
      14'd0:   w_rdata = {12'h000, w_pend, r_ovf, r_esc, r_en};
      14'd1:   w_rdata = r_vpc;
      14'd2:   w_rdata = r_vid;
      14'd3:   w_rdata = r_vprev;
      14'd4:   w_rdata = {14'h0000, r_cause};
      14'd5:   w_rdata = r_count;
      default: w_rdata = 16'h0000;
    endcase
  end

  assign bus.per_dout  = w_rd ? w_rdata : 16'h0000;
  assign viol_irq      = r_irq;
  assign viol_rst_req  = r_rst_req;

endmodule

// File: tb/tb_omsp_spm_violation_ctl.sv
// Bench for omsp_spm_violation_ctl: register dumps from a vector table
// plus hand-written sequences for PEND/OVF/ESCAL/reset corner cases.
module tb_omsp_spm_violation_ctl;

  localparam logic [13:0] BASE = 14'h0190;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        violation = 1'b0;
  logic        exec_violation = 1'b0;
  logic        irq_acc = 1'b0;
  logic [15:0] spm_current_id = 16'h0;
  logic [15:0] spm_prev_id = 16'h0;
  logic [15:0] pc = 16'h0;
  logic        viol_irq;
  logic        viol_rst_req;

  omsp_spm_violation_ctl_if bus();

  omsp_spm_violation_ctl #(
    .BASE_ADDR (14'h0190),
    .RST_CYCLES(8)
  ) dut (
    .mclk          (mclk),
    .puc_rst_n     (puc_rst_n),
    .violation     (violation),
    .exec_violation(exec_violation),
    .spm_current_id(spm_current_id),
    .spm_prev_id   (spm_prev_id),
    .pc            (pc),
    .irq_acc       (irq_acc),
    .bus           (bus),
    .viol_irq      (viol_irq),
    .viol_rst_req  (viol_rst_req)
  );

  always #10 mclk = ~mclk;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    logic [13:0] off;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  sb_t   sbq[$];
  vec_t  tbl[6];
  string nms[6] = '{"CTL", "VPC", "VID", "VPREV", "CAUSE", "COUNT"};
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic sb_push(input string nm, input logic [15:0] exp);
    sb_t e;
    e.nm  = nm;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] act);
    sb_t e;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %h with nothing expected", act);
      return;
    end
    e = sbq.pop_front();
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    sb_push(nm, exp);
    sb_pop(act);
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic rd(input logic [13:0] off, input logic [15:0] exp,
                    input string nm);
    sb_push(nm, exp);
    bus.per_en   = 1'b1;
    bus.per_we   = 2'b00;
    bus.per_addr = BASE + off;
    #1;
    sb_pop(bus.per_dout);
    bus.per_en   = 1'b0;
  endtask

  task automatic wr(input logic [13:0] off, input logic [15:0] d,
                    input logic [1:0] we);
    bus.per_en   = 1'b1;
    bus.per_we   = we;
    bus.per_addr = BASE + off;
    bus.per_din  = d;
    tick();
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
  endtask

  task automatic set_tbl(input logic [15:0] ctl, input logic [15:0] vpc,
                         input logic [15:0] vid, input logic [15:0] vprev,
                         input logic [15:0] cause, input logic [15:0] cnt);
    logic [15:0] e[6];
    e = '{ctl, vpc, vid, vprev, cause, cnt};
    for (int i = 0; i < 6; i++) begin
      tbl[i].off = 14'(i);
      tbl[i].exp = e[i];
      tbl[i].nm  = nms[i];
    end
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < 6; i++) begin
      rd(tbl[i].off, tbl[i].exp, {tag, ".", tbl[i].nm});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int bad;
    logic [15:0] pcs[3];
    pcs = '{16'h9000, 16'h9002, 16'h9004};

    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    bus.per_addr = BASE;
    bus.per_din  = 16'h0;

    repeat (3) tick();
    chk("rst_irq", 16'(viol_irq), 16'h0);
    chk("rst_rstreq", 16'(viol_rst_req), 16'h0);
    puc_rst_n = 1'b1;
    tick();
    chk("dout_idle", bus.per_dout, 16'h0);
    set_tbl(16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_tbl("rst");

    // first violation: capture and PEND
    pc = 16'h8010;
    spm_current_id = 16'd3;
    spm_prev_id = 16'd0;
    violation = 1'b1;
    tick();
    chk("p1_irq", 16'(viol_irq), 16'h1);
    set_tbl(16'h9, 16'h8010, 16'h3, 16'h0, 16'h1, 16'h1);
    run_tbl("p1");
    repeat (5) tick();
    rd(14'd5, 16'h1, "p1_hold.COUNT");
    chk("p1_hold_irq", 16'(viol_irq), 16'h1);

    // acknowledge
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;
    chk("p2_ack_irq", 16'(viol_irq), 16'h0);
    rd(14'd0, 16'h1, "p2_ack.CTL");
    wr(14'd0, 16'h4, 2'b11);
    rd(14'd0, 16'h0, "p2_ovf_clr_idle.CTL");

    // second capture, then overflow with ESC=0
    violation = 1'b0;
    wr(14'd0, 16'h1, 2'b11);
    rd(14'd0, 16'h1, "p3_en.CTL");
    pc = 16'h8020;
    spm_current_id = 16'd5;
    spm_prev_id = 16'd3;
    violation = 1'b1;
    tick();
    chk("p3_irq", 16'(viol_irq), 16'h1);
    pc = 16'h8030;
    spm_current_id = 16'd7;
    exec_violation = 1'b1;
    tick();
    set_tbl(16'hD, 16'h8020, 16'h5, 16'h3, 16'h1, 16'h3);
    run_tbl("p3_ovf");
    exec_violation = 1'b0;
    tick();
    exec_violation = 1'b1;
    wr(14'd0, 16'h5, 2'b11);
    rd(14'd0, 16'hD, "p3_hw_wins.CTL");
    rd(14'd5, 16'h4, "p3_hw_wins.COUNT");
    exec_violation = 1'b0;
    wr(14'd0, 16'h5, 2'b11);
    rd(14'd0, 16'h9, "p3_ovf_clr.CTL");

    // escalation with ESC=1
    wr(14'd0, 16'h3, 2'b11);
    rd(14'd0, 16'hB, "p4_esc.CTL");
    violation = 1'b0;
    tick();
    pc = 16'h8040;
    violation = 1'b1;
    hi = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (viol_rst_req) begin
        hi++;
        if (viol_irq) bad++;
      end else if (hi > 0) begin
        break;
      end
      if (c == 1) violation = 1'b0;
      if (c == 2) irq_acc = 1'b1;
      if (c == 3) begin
        violation = 1'b1;
        irq_acc = 1'b0;
      end
    end
    chk("p4_rst_len", 16'(hi), 16'd8);
    chk("p4_irq_in_escal", 16'(bad), 16'd0);
    chk("p4_irq_after", 16'(viol_irq), 16'h0);
    set_tbl(16'h3, 16'h8020, 16'h5, 16'h3, 16'h1, 16'h6);
    run_tbl("p4_after");

    // reset asserted while in ESCAL
    violation = 1'b0;
    tick();
    violation = 1'b1;
    tick();
    chk("p6_pend_irq", 16'(viol_irq), 16'h1);
    violation = 1'b0;
    tick();
    violation = 1'b1;
    tick();
    chk("p6_escal", 16'(viol_rst_req), 16'h1);
    repeat (2) tick();
    #2;
    puc_rst_n = 1'b0;
    #1;
    chk("p6_async_rstreq", 16'(viol_rst_req), 16'h0);
    chk("p6_async_irq", 16'(viol_irq), 16'h0);
    violation = 1'b0;
    set_tbl(16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_tbl("p6_rst");
    tick();
    puc_rst_n = 1'b1;
    tick();
    rd(14'd6, 16'h0, "p6_unmapped");

    // disabled: count only
    wr(14'd0, 16'h0, 2'b11);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i];
      violation = 1'b1;
      tick();
      if (viol_irq) bad++;
      violation = 1'b0;
      tick();
      if (viol_irq) bad++;
    end
    chk("p5_irq_never", 16'(bad), 16'd0);
    set_tbl(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3);
    run_tbl("p5");
    violation = 1'b1;
    wr(14'd5, 16'hDEAD, 2'b01);
    rd(14'd5, 16'h1, "p5_clr_evt.COUNT");
    violation = 1'b0;
    tick();

    // ack coinciding with a new event recaptures
    wr(14'd0, 16'h1, 2'b11);
    pc = 16'h8050;
    spm_current_id = 16'd9;
    spm_prev_id = 16'd2;
    violation = 1'b1;
    tick();
    chk("p7_irq", 16'(viol_irq), 16'h1);
    violation = 1'b0;
    tick();
    pc = 16'h8060;
    spm_current_id = 16'd10;
    spm_prev_id = 16'd9;
    exec_violation = 1'b1;
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;
    chk("p7_ackevt_irq", 16'(viol_irq), 16'h1);
    set_tbl(16'h9, 16'h8060, 16'hA, 16'h9, 16'h2, 16'h3);
    run_tbl("p7");
    bus.per_en   = 1'b1;
    bus.per_we   = 2'b10;
    bus.per_addr = BASE + 14'd1;
    bus.per_din  = 16'h0;
    #1;
    chk("p7_dout_on_wr", bus.per_dout, 16'h0);
    tick();
    bus.per_en = 1'b0;
    bus.per_we = 2'b00;
    rd(14'd1, 16'h8060, "p7_ro_wr.VPC");
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;
    exec_violation = 1'b0;
    chk("p7_final_irq", 16'(viol_irq), 16'h0);
    rd(14'd0, 16'h1, "p7_final.CTL");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
